// File: rtl/win_scanner.sv
// Sequential N x N tic-tac-toe win detector: captures both boards, scans one line per cycle.
// Optional draw detection is built only when WIN_SCANNER_DRAW_EN is defined.
module win_scanner #(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N*N-1:0]   ain,
  input  logic [N*N-1:0]   bin,
  output logic             busy,
  output logic             done,
  output logic [2*N+1:0]   win_line,
  output logic             a_win,
  output logic             b_win,
  output logic             illegal,
  output logic             draw
);

  localparam int NN = N * N;
  localparam int L  = 2 * N + 2;
  localparam int IW = $clog2(L);
  localparam logic [IW-1:0] LAST_IDX = IW'(L - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Cell mask of line l; cell (r,c) lives at bit NN-1-(r*N+c).
  function automatic logic [NN-1:0] line_mask(input int l);
    logic [NN-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++) begin
      if (l < N)
        m[NN-1-(l*N+k)] = 1'b1;
      else if (l < 2*N)
        m[NN-1-(k*N+(l-N))] = 1'b1;
      else if (l == 2*N)
        m[NN-1-(k*N+k)] = 1'b1;
      else
        m[NN-1-(k*N+(N-1-k))] = 1'b1;
    end
    return m;
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NN-1:0]   a_cap_q, a_cap_d;
  logic [NN-1:0]   b_cap_q, b_cap_d;
  logic            ill_cap_q, ill_cap_d;
  logic [L-1:0]    line_sh_q, line_sh_d;
  logic            a_sh_q, a_sh_d;
  logic            b_sh_q, b_sh_d;
  logic [L-1:0]    win_line_q, win_line_d;
  logic            a_win_q, a_win_d;
  logic            b_win_q, b_win_d;
  logic            illegal_q, illegal_d;
`ifdef WIN_SCANNER_DRAW_EN
  logic            full_q, full_d;
  logic            draw_q, draw_d;
`endif

  logic [L-1:0]    a_line_vec;
  logic [L-1:0]    b_line_vec;
  logic            a_hit;
  logic            b_hit;

  // Per-line completion against the captured boards; the scan selects one per cycle.
  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_line
      localparam logic [NN-1:0] MASK = line_mask(gi);
      assign a_line_vec[gi] = &(a_cap_q | ~MASK);
      assign b_line_vec[gi] = &(b_cap_q | ~MASK);
    end
  endgenerate

  assign a_hit = a_line_vec[idx_q];
  assign b_hit = b_line_vec[idx_q];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_cap_d    = a_cap_q;
    b_cap_d    = b_cap_q;
    ill_cap_d  = ill_cap_q;
    line_sh_d  = line_sh_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    win_line_d = win_line_q;
    a_win_d    = a_win_q;
    b_win_d    = b_win_q;
    illegal_d  = illegal_q;
`ifdef WIN_SCANNER_DRAW_EN
    full_d     = full_q;
    draw_d     = draw_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          idx_d     = '0;
          a_cap_d   = ain;
          b_cap_d   = bin;
          ill_cap_d = |(ain & bin);
          line_sh_d = '0;
          a_sh_d    = 1'b0;
          b_sh_d    = 1'b0;
`ifdef WIN_SCANNER_DRAW_EN
          full_d    = &(ain | bin);
`endif
        end
      end
      SCAN: begin
        line_sh_d[idx_q] = a_hit | b_hit;
        a_sh_d           = a_sh_q | a_hit;
        b_sh_d           = b_sh_q | b_hit;
        if (idx_q == LAST_IDX) begin
          // Publish includes the line evaluated in this final cycle.
          state_d    = DONE;
          win_line_d = line_sh_d;
          a_win_d    = a_sh_d;
          b_win_d    = b_sh_d;
          illegal_d  = ill_cap_q;
`ifdef WIN_SCANNER_DRAW_EN
          draw_d     = full_q & ~a_sh_d & ~b_sh_d & ~ill_cap_q;
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_cap_q    <= '0;
      b_cap_q    <= '0;
      ill_cap_q  <= 1'b0;
      line_sh_q  <= '0;
      a_sh_q     <= 1'b0;
      b_sh_q     <= 1'b0;
      win_line_q <= '0;
      a_win_q    <= 1'b0;
      b_win_q    <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef WIN_SCANNER_DRAW_EN
      full_q     <= 1'b0;
      draw_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_cap_q    <= a_cap_d;
      b_cap_q    <= b_cap_d;
      ill_cap_q  <= ill_cap_d;
      line_sh_q  <= line_sh_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      win_line_q <= win_line_d;
      a_win_q    <= a_win_d;
      b_win_q    <= b_win_d;
      illegal_q  <= illegal_d;
`ifdef WIN_SCANNER_DRAW_EN
      full_q     <= full_d;
      draw_q     <= draw_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign win_line = win_line_q;
  assign a_win    = a_win_q;
  assign b_win    = b_win_q;
  assign illegal  = illegal_q;
`ifdef WIN_SCANNER_DRAW_EN
  assign draw     = draw_q;
`else
  assign draw     = 1'b0;
`endif

endmodule

// File: tb/tb_win_scanner.sv
// Directed bench for win_scanner: N=3 and N=4 instances, scoreboard of expected scan results.
module tb_win_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start3, start4;
  logic [8:0]  ain3, bin3;
  logic [15:0] ain4, bin4;
  logic        busy3, done3, a3, b3, ill3, draw3;
  logic        busy4, done4, a4, b4, ill4, draw4;
  logic [7:0]  line3;
  logic [9:0]  line4;

`ifdef WIN_SCANNER_DRAW_EN
  localparam logic DRAW_EXP = 1'b1;
`else
  localparam logic DRAW_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  win_scanner #(.N(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .ain(ain3), .bin(bin3),
    .busy(busy3), .done(done3), .win_line(line3), .a_win(a3), .b_win(b3),
    .illegal(ill3), .draw(draw3)
  );

  win_scanner #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .ain(ain4), .bin(bin4),
    .busy(busy4), .done(done4), .win_line(line4), .a_win(a4), .b_win(b4),
    .illegal(ill4), .draw(draw4)
  );

  typedef struct {
    logic [15:0] line;
    logic        a;
    logic        b;
    logic        ill;
    logic        drw;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? done4 : done3;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy4 : busy3;
  endfunction

  // Drive one scan, optionally disturbing inputs mid-scan, then compare against the scoreboard.
  task automatic scan(input bit sel, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eline, input logic ea, input logic eb,
                      input logic eill, input logic edrw, input int elat,
                      input int chg_cyc, input logic [15:0] chg_val, input int restart_cyc);
    exp_t e;
    exp_t got;
    int   cyc;
    logic seen;
    e.line = eline; e.a = ea; e.b = eb; e.ill = eill; e.drw = edrw; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    if (sel) begin ain4 = a; bin4 = b; start4 = 1'b1; end
    else begin ain3 = a[8:0]; bin3 = b[8:0]; start3 = 1'b1; end
    cyc = 0;
    seen = 1'b0;
    while (cyc < 40 && !seen) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1 || cyc == restart_cyc + 1) begin start3 = 1'b0; start4 = 1'b0; end
      if (cyc == chg_cyc) ain3 = chg_val[8:0];
      if (cyc == restart_cyc) start3 = 1'b1;
      if (cyc == 1) chk("busy_after_start", {31'b0, get_busy(sel)}, 32'd1);
      seen = get_done(sel);
    end
    start3 = 1'b0;
    start4 = 1'b0;
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk("sb_empty_at_done", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      $display("scan dut%0d ain=%h bin=%h latency=%0d win_line=%h a=%0b b=%0b ill=%0b draw=%0b",
               sel ? 4 : 3, a, b, cyc, sel ? {6'b0, line4} : {8'b0, line3},
               sel ? a4 : a3, sel ? b4 : b3, sel ? ill4 : ill3, sel ? draw4 : draw3);
      chk("latency", cyc, got.lat);
      chk("win_line", sel ? {22'b0, line4} : {24'b0, line3}, {16'b0, got.line});
      chk("a_win", {31'b0, sel ? a4 : a3}, {31'b0, got.a});
      chk("b_win", {31'b0, sel ? b4 : b3}, {31'b0, got.b});
      chk("illegal", {31'b0, sel ? ill4 : ill3}, {31'b0, got.ill});
      chk("draw", {31'b0, sel ? draw4 : draw3}, {31'b0, got.drw});
      chk("busy_in_done", {31'b0, get_busy(sel)}, 32'd1);
      @(posedge clk);
      #1;
      chk("done_one_cycle", {31'b0, get_done(sel)}, 32'd0);
      chk("idle_after_done", {31'b0, get_busy(sel)}, 32'd0);
      chk("held_win_line", sel ? {22'b0, line4} : {24'b0, line3}, {16'b0, got.line});
    end
  endtask

  int dcount;
  int bcount;

  initial begin
    reset = 1'b1; start3 = 1'b0; start4 = 1'b0;
    ain3 = '0; bin3 = '0; ain4 = '0; bin4 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", {31'b0, busy3}, 32'd0);
    chk("rst_done", {31'b0, done3}, 32'd0);
    chk("rst_line3", {24'b0, line3}, 32'd0);
    chk("rst_flags3", {28'b0, a3, b3, ill3, draw3}, 32'd0);
    chk("rst_line4", {22'b0, line4}, 32'd0);
    chk("rst_flags4", {26'b0, busy4, done4, a4, b4, ill4, draw4}, 32'd0);

    // Idle with start low: nothing happens.
    dcount = 0; bcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done3) dcount++;
      if (busy3) bcount++;
    end
    chk("idle_no_done", dcount, 32'd0);
    chk("idle_no_busy", bcount, 32'd0);

    // Row 0 for A.
    scan(1'b0, 16'h01C0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 9, 0, 16'h0, 0);

    // Reset at cycle 5 of a scan: no done, published outputs clear.
    @(negedge clk);
    ain3 = 9'b111_000_000; bin3 = '0; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    repeat (4) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    dcount = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done3) dcount++;
    end
    chk("abort_no_done", dcount, 32'd0);
    chk("abort_line", {24'b0, line3}, 32'd0);
    chk("abort_flags", {28'b0, a3, b3, ill3, busy3}, 32'd0);
    $display("scan dut3 aborted by reset, win_line=%h", line3);

    // B up-diagonal, then A column 0.
    scan(1'b0, 16'h0000, 16'h0054, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, 9, 0, 16'h0, 0);
    scan(1'b0, 16'h0124, 16'h0000, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 9, 0, 16'h0, 0);

    // Input change at cycle 3 and extra start at cycle 4 must not matter.
    scan(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 9, 3, 16'h0038, 4);
    dcount = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done3) dcount++;
    end
    chk("restart_ignored", dcount, 32'd0);
    ain3 = '0;

    // Both players win; full board but no draw.
    scan(1'b0, 16'h01F8, 16'h0007, 16'h0007, 1'b1, 1'b1, 1'b0, 1'b0, 9, 0, 16'h0, 0);
    // Overlap marks the board illegal.
    scan(1'b0, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 9, 0, 16'h0, 0);

    // N=4: A5A5 completes both diagonals (A down, B up); C3C3 is a genuine draw.
    scan(1'b1, 16'hA5A5, 16'h5A5A, 16'h0300, 1'b1, 1'b1, 1'b0, 1'b0, 11, 0, 16'h0, 0);
    scan(1'b1, 16'hC3C3, 16'h3C3C, 16'h0000, 1'b0, 1'b0, 1'b0, DRAW_EXP, 11, 0, 16'h0, 0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
